// File: rtl/multi_clap_detector.sv
// rtl/multi_clap_detector.sv - counts claps in a sequence of audio threshold hits
// A hit is re-armed only after a holdoff; the sequence closes on window expiry or when it reaches MAX_CLAPS.
module multi_clap_detector #(
  parameter int                  SAMPLE_W       = 16,
  parameter int                  NUM_CH         = 2,
  parameter logic [SAMPLE_W-1:0] THRESH         = 16'h4000,
  parameter int                  HOLDOFF_CYCLES = 4800,
  parameter int                  WINDOW_CYCLES  = 24000,
  parameter int                  MAX_CLAPS      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  output logic                       clap_pulse,
  output logic                       yesClap,
  output logic                       count_valid,
  output logic [3:0]                 clap_count
);

  localparam int TIMER_MAX = (HOLDOFF_CYCLES > WINDOW_CYCLES) ? HOLDOFF_CYCLES : WINDOW_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TIMER_W-1:0]  HOLDOFF_LOAD = TIMER_W'(HOLDOFF_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  WINDOW_LOAD  = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [3:0]          MAX_COUNT    = 4'(MAX_CLAPS);
  localparam logic [SAMPLE_W-1:0] MOST_NEG     = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MAG_SAT      = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDOFF = 2'd1,
    WINDOW  = 2'd2,
    REPORT  = 2'd3
  } state_t;

  logic [NUM_CH-1:0] ch_hit;
  logic              hit;

  // The most negative sample has no positive twin, so it saturates instead of wrapping.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_mag
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] mag;
    assign sample    = sample_data[k*SAMPLE_W +: SAMPLE_W];
    assign mag       = !sample[SAMPLE_W-1] ? sample :
                       (sample == MOST_NEG) ? MAG_SAT : (~sample + SAMPLE_W'(1));
    assign ch_hit[k] = (mag >= THRESH);
  end

  assign hit = sample_valid & enable & (|ch_hit);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         count_q, count_d;
  logic [3:0]         count_inc;
  logic               clap_pulse_q, clap_pulse_d;
  logic               yes_clap_q, yes_clap_d;
  logic               count_valid_q, count_valid_d;
  logic [3:0]         clap_count_q, clap_count_d;

  assign count_inc = count_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    count_d       = count_q;
    clap_pulse_d  = 1'b0;
    count_valid_d = 1'b0;
    clap_count_d  = clap_count_q;

    if (!enable) begin
      state_d = IDLE;
      timer_d = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            clap_pulse_d = 1'b1;
            count_d      = 4'd1;
            if (MAX_COUNT == 4'd1) begin
              state_d = REPORT;
              timer_d = '0;
            end else begin
              state_d = HOLDOFF;
              timer_d = HOLDOFF_LOAD;
            end
          end
        end
        HOLDOFF: begin
          if (timer_q == '0) begin
            state_d = WINDOW;
            timer_d = WINDOW_LOAD;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        WINDOW: begin
          // A hit on the final window cycle still counts: hit wins over expiry.
          if (hit) begin
            clap_pulse_d = 1'b1;
            count_d      = count_inc;
            if (count_inc < MAX_COUNT) begin
              state_d = HOLDOFF;
              timer_d = HOLDOFF_LOAD;
            end else begin
              state_d = REPORT;
              timer_d = '0;
            end
          end else if (timer_q == '0) begin
            state_d = REPORT;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        REPORT: begin
          count_valid_d = 1'b1;
          clap_count_d  = count_q;
          count_d       = '0;
          timer_d       = '0;
          state_d       = IDLE;
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
          count_d = '0;
        end
      endcase
    end

    yes_clap_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      count_q       <= '0;
      clap_pulse_q  <= 1'b0;
      yes_clap_q    <= 1'b0;
      count_valid_q <= 1'b0;
      clap_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      clap_pulse_q  <= clap_pulse_d;
      yes_clap_q    <= yes_clap_d;
      count_valid_q <= count_valid_d;
      clap_count_q  <= clap_count_d;
    end
  end

  assign clap_pulse  = clap_pulse_q;
  assign yesClap     = yes_clap_q;
  assign count_valid = count_valid_q;
  assign clap_count  = clap_count_q;

endmodule

// File: tb/tb_multi_clap_detector.sv
// tb/tb_multi_clap_detector.sv - scoreboard bench for multi_clap_detector
// The model tracks the last accepted clap time and derives holdoff/window membership from the elapsed cycles.
module tb_multi_clap_detector;

  localparam int SW   = 16;
  localparam int NCH  = 2;
  localparam int H    = 8;
  localparam int W    = 20;
  localparam int MAXC = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            sample_valid = 1'b0;
  logic [NCH*SW-1:0] sample_data = '0;
  logic            clap_pulse;
  logic            yesClap;
  logic            count_valid;
  logic [3:0]      clap_count;

  multi_clap_detector #(
    .SAMPLE_W       (SW),
    .NUM_CH         (NCH),
    .THRESH         (16'h4000),
    .HOLDOFF_CYCLES (H),
    .WINDOW_CYCLES  (W),
    .MAX_CLAPS      (MAXC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .clap_pulse   (clap_pulse),
    .yesClap      (yesClap),
    .count_valid  (count_valid),
    .clap_count   (clap_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pulse;
    logic       cv;
    logic       yes;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state: elapsed-time view of the clap sequence.
  int   edge_n = 0;
  bit   m_open = 1'b0;
  int   m_last = 0;
  int   m_count = 0;
  int   m_report_at = -1;
  int   m_clap_count = 0;

  function automatic bit chan_hit(input logic [15:0] s);
    int v;
    int m;
    v = $signed(s);
    m = (v < 0) ? -v : v;
    if (m > 32767) m = 32767;
    return (m >= 16384);
  endfunction

  function automatic logic [15:0] rnd_sample();
    logic [15:0] s;
    case ($urandom_range(0, 7))
      0:       s = 16'h8000;
      1:       s = 16'h4000;
      2:       s = 16'h3FFF;
      3:       s = 16'hC000;
      4:       s = 16'hC001;
      5:       s = 16'h7FFF;
      default: s = 16'($urandom);
    endcase
    return s;
  endfunction

  task automatic model_accept(inout exp_t e);
    m_count = m_count + 1;
    m_last  = edge_n;
    m_open  = 1'b1;
    e.pulse = 1'b1;
    if (m_count == MAXC) m_report_at = edge_n + 1;
  endtask

  task automatic step(input bit en, input bit vld, input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    bit   hit;
    int   d;
    @(negedge clk);
    reset        = 1'b0;
    enable       = en;
    sample_valid = vld;
    sample_data  = {r, l};
    hit = en && vld && (chan_hit(l) || chan_hit(r));
    e = '0;
    if (!en) begin
      m_open      = 1'b0;
      m_count     = 0;
      m_report_at = -1;
    end else if (m_report_at == edge_n) begin
      e.cv         = 1'b1;
      m_clap_count = m_count;
      m_count      = 0;
      m_open       = 1'b0;
      m_report_at  = -1;
    end else if (!m_open) begin
      if (hit) model_accept(e);
    end else if (m_report_at < 0) begin
      d = edge_n - m_last;
      if (hit && d > H && d <= H + W) model_accept(e);
      else if (d >= H + W) m_report_at = edge_n + 1;
    end
    e.yes = m_open;
    e.cnt = 4'(m_clap_count);
    exp_q.push_back(e);
    edge_n++;
  endtask

  task automatic pulse_reset();
    exp_t e;
    @(negedge clk);
    reset        = 1'b1;
    enable       = 1'b1;
    sample_valid = 1'b0;
    m_open       = 1'b0;
    m_count      = 0;
    m_report_at  = -1;
    m_clap_count = 0;
    e = '0;
    exp_q.push_back(e);
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic hit_lr(input logic [15:0] l, input logic [15:0] r);
    step(1'b1, 1'b1, l, r);
  endtask

  // Scoreboard monitor: one expected output tuple per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({clap_pulse, count_valid, yesClap, clap_count} === e) passes++;
        else $display("FAIL outputs at check %0d: actual pulse=%b cv=%b yes=%b cnt=%0d, required pulse=%b cv=%b yes=%b cnt=%0d",
                      checks, clap_pulse, count_valid, yesClap, clap_count, e.pulse, e.cv, e.yes, e.cnt);
      end
    end
  end

  initial begin
    int sel;
    int rate;
    bit en;
    bit vld;

    pulse_reset();
    pulse_reset();

    // Single hit runs the full holdoff and window, then reports 1.
    hit_lr(16'h5000, 16'h0000);
    idle(35);

    // Saturated and exact-threshold negatives are hits; just below threshold is not.
    hit_lr(16'h0000, 16'h8000);
    idle(35);
    hit_lr(16'hC000, 16'h0000);
    idle(35);
    hit_lr(16'h3FFF, 16'h0000);
    hit_lr(16'hC001, 16'h3FFF);
    step(1'b1, 1'b0, 16'h7FFF, 16'h8000);
    idle(3);

    // Hit inside holdoff is ignored; hit in window extends to 2.
    hit_lr(16'h5000, 16'h0000);
    idle(3);
    hit_lr(16'h5000, 16'h0000);
    idle(10);
    hit_lr(16'h0000, 16'h6000);
    idle(35);

    // Three claps close the sequence immediately.
    hit_lr(16'h5000, 16'h0000);
    idle(10);
    hit_lr(16'h5000, 16'h0000);
    idle(10);
    hit_lr(16'h5000, 16'h0000);
    idle(5);

    // Hit on the last window cycle is accepted.
    hit_lr(16'h5000, 16'h0000);
    idle(H + W - 1);
    hit_lr(16'h5000, 16'h0000);
    idle(35);

    // Hit during the report cycle is ignored; the next cycle starts afresh.
    hit_lr(16'h5000, 16'h0000);
    idle(H + W);
    hit_lr(16'h5000, 16'h0000);
    hit_lr(16'h5000, 16'h0000);
    idle(35);

    // Enable dropped mid-window with count 2 keeps the previous clap_count.
    hit_lr(16'h5000, 16'h0000);
    idle(10);
    hit_lr(16'h5000, 16'h0000);
    idle(12);
    step(1'b0, 1'b1, 16'h5000, 16'h5000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(5);

    // Reset mid-window with count 2 aborts the sequence and clears clap_count.
    hit_lr(16'h5000, 16'h0000);
    idle(10);
    hit_lr(16'h5000, 16'h0000);
    idle(12);
    pulse_reset();
    hit_lr(16'h5000, 16'h0000);
    idle(35);

    for (int i = 0; i < 3000; i++) begin
      rate = (i < 1500) ? 4 : 20;
      sel  = $urandom_range(0, 999);
      if (sel < 3) begin
        pulse_reset();
      end else begin
        en  = ($urandom_range(0, 99) < 97);
        vld = ($urandom_range(0, 99) < rate);
        step(en, vld, rnd_sample(), rnd_sample());
      end
    end

    idle(3);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard drain: actual %0d pending, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_clap_detector.md
MULTI_CLAP_DETECTOR -- requirements
Module: multi_clap_detector

Interface
REQ-001 Parameter SAMPLE_W, 16, width of one signed two's-complement audio sample.
REQ-002 Parameter NUM_CH, 2, number of audio channels (left/right = 2).
REQ-003 Parameter THRESH, 16'h4000, magnitude at or above which a sample counts as a hit; unsigned, SAMPLE_W bits.
REQ-004 Parameter HOLDOFF_CYCLES, 4800, clock cycles during which hits are ignored after an accepted clap; minimum 1.
REQ-005 Parameter WINDOW_CYCLES, 24000, clock cycles after holdoff in which a further clap extends the sequence; minimum 1.
REQ-006 Parameter MAX_CLAPS, 4, sequence length that closes the sequence immediately; range 1 to 15.
REQ-007 clk  input  1  single system clock; all state is on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  detector run enable; low forces the idle state.
REQ-010 sample_valid  input  1  one-cycle strobe qualifying sample_data.
REQ-011 sample_data  input  NUM_CH*SAMPLE_W  packed signed samples; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W].
REQ-012 clap_pulse  output  1  one-cycle pulse per accepted clap.
REQ-013 yesClap  output  1  level, high while a clap sequence is open (any state but IDLE).
REQ-014 count_valid  output  1  one-cycle pulse when a sequence closes.
REQ-015 clap_count  output  4  number of claps in the closed sequence; held until the next count_valid.

Function
REQ-016 Magnitude per channel SHALL be |x|; the most negative value SHALL saturate to 2^(SAMPLE_W-1)-1, with no wrap.
REQ-017 hit SHALL be sample_valid AND enable AND (any channel magnitude >= THRESH); hits are evaluated only on sample_valid cycles.
REQ-018 The FSM SHALL have exactly the states IDLE, HOLDOFF, WINDOW and REPORT.
REQ-019 IDLE + hit: the next cycle SHALL give clap_pulse=1, running count=1 and state HOLDOFF, with the timer loaded to HOLDOFF_CYCLES-1.
REQ-020 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles; hits are ignored; on timer==0 it goes to WINDOW, with the timer loaded to WINDOW_CYCLES-1.
REQ-021 WINDOW + hit: clap_pulse SHALL pulse next cycle and the count SHALL increment; if the new count < MAX_CLAPS the state goes to HOLDOFF, otherwise to REPORT.
REQ-022 WINDOW with timer==0 and no hit SHALL go to REPORT; a hit on the final window cycle SHALL be accepted (hit has priority over expiry).
REQ-023 REPORT SHALL last one cycle: count_valid=1, clap_count=running count, running count cleared, next state IDLE.
REQ-024 A hit arriving in REPORT SHALL be ignored.
REQ-025 clap_pulse, count_valid, yesClap and clap_count SHALL be registered outputs; hit-to-clap_pulse latency is 1 cycle.
REQ-026 enable low in any state SHALL go to IDLE on the next edge, clear the running count and timer, suppress count_valid, and leave clap_count unchanged.
REQ-027 Timers SHALL be sized $clog2(max(HOLDOFF_CYCLES,WINDOW_CYCLES)) bits minimum 1; the running count SHALL never exceed MAX_CLAPS.
REQ-028 With MAX_CLAPS=1 the state after the first hit SHALL be REPORT directly, skipping HOLDOFF.

Reset
REQ-029 While reset is high: state IDLE, timer 0, running count 0, clap_pulse 0, yesClap 0, count_valid 0, clap_count 0.
REQ-030 Reset asserted mid-sequence SHALL abort it with no count_valid; the first rising edge after deassertion sees IDLE.

Verification (NUM_CH=2, SAMPLE_W=16, THRESH=16'h4000, HOLDOFF_CYCLES=8, WINDOW_CYCLES=20, MAX_CLAPS=3)
REQ-031 Single hit L=16'h5000 at cycle t -> clap_pulse at t+1; REPORT after 8+20 cycles; count_valid with clap_count=1; yesClap high t+1 through REPORT.
REQ-032 R=16'h8000 (saturated) and L=16'hC000 (|x|=0x4000) -> each is a hit; L=16'h3FFF alone -> no hit.
REQ-033 Hits at t, t+4 (inside holdoff), t+15 -> exactly 2 clap_pulses; closes with clap_count=2.
REQ-034 Three spaced hits inside their windows -> third hit goes straight to REPORT; clap_count=3 one cycle after the third clap_pulse.
REQ-035 Hit on the last WINDOW cycle -> accepted, count increments, no premature count_valid.
REQ-036 enable dropped, or reset pulsed, mid-WINDOW with count=2 -> IDLE, yesClap=0, no count_valid; clap_count keeps its prior value on enable drop and is 0 on reset.
